// File: rtl/wash_seq_if.sv
// Control/status bundle between the washer program sequencer and its user.
interface wash_seq_if;
  logic       start;
  logic       pause;
  logic       abort;
  logic [1:0] motor;
  logic       water_in;
  logic       water_out;
  logic       busy;
  logic       done;
  logic [2:0] phase;

  modport master (
    output start, pause, abort,
    input  motor, water_in, water_out, busy, done, phase
  );
  modport slave (
    input  start, pause, abort,
    output motor, water_in, water_out, busy, done, phase
  );
endinterface

// File: rtl/wash_seq_ctrl.sv
// Washer program sequencer: wash pass, RINSE_REP rinse passes, spin; all
// phase timing from a tick prescaler, with pause/resume and abort-to-drain.
module wash_seq_ctrl #(
  parameter int TICK_DIV  = 2,
  parameter int T_W       = 4,
  parameter int FILL_T    = 3,
  parameter int CW_T      = 4,
  parameter int CCW_T     = 4,
  parameter int PAUSE_T   = 2,
  parameter int AGIT_REP  = 2,
  parameter int DRAIN_T   = 3,
  parameter int RINSE_REP = 1,
  parameter int SPIN_T    = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  wash_seq_if.slave   bus
);
  localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW  = (AGIT_REP > 1) ? $clog2(AGIT_REP) : 1;
  localparam int RW  = (RINSE_REP > 0) ? $clog2(RINSE_REP + 1) : 1;
  localparam logic [PSW-1:0] PSC_LAST  = PSW'(TICK_DIV - 1);
  localparam logic [AW-1:0]  AGIT_LAST = AW'(AGIT_REP - 1);
  localparam logic [RW-1:0]  PASS_LAST = RW'(RINSE_REP);

  typedef enum logic [3:0] {
    S_IDLE, S_FILL, S_CW, S_P1, S_CCW, S_P2, S_DRAIN, S_SPIN, S_ABORT
  } state_e;

  state_e         state_q, state_d;
  logic [PSW-1:0] psc_q, psc_d;
  logic [T_W-1:0] tmr_q, tmr_d;
  logic [AW-1:0]  agit_q, agit_d;
  logic [RW-1:0]  pass_q, pass_d;
  logic           done_q, done_d;
  logic           hold_q;
  logic [T_W-1:0] dur;
  logic           tick, phase_end, run, adv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      psc_q   <= '0;
      tmr_q   <= '0;
      agit_q  <= '0;
      pass_q  <= '0;
      done_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      tmr_q   <= tmr_d;
      agit_q  <= agit_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      hold_q  <= bus.pause;
    end
  end

  always_comb begin
    dur = T_W'(1);
    case (state_q)
      S_FILL:          dur = T_W'(FILL_T);
      S_CW:            dur = T_W'(CW_T);
      S_CCW:           dur = T_W'(CCW_T);
      S_P1, S_P2:      dur = T_W'(PAUSE_T);
      S_DRAIN, S_ABORT: dur = T_W'(DRAIN_T);
      S_SPIN:          dur = T_W'(SPIN_T);
      default:         dur = T_W'(1);
    endcase
  end

  assign tick      = (psc_q == PSC_LAST);
  assign phase_end = tick && (tmr_q == dur - 1'b1);
  assign run       = (state_q != S_IDLE) && !bus.pause;

  always_comb begin
    state_d = state_q;
    agit_d  = agit_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      if (bus.start) begin
        state_d = S_FILL;
        agit_d  = '0;
        pass_d  = '0;
      end
    end else if (bus.abort && state_q != S_ABORT) begin
      // abort wins over pause and over a coincident phase end
      state_d = S_ABORT;
    end else if (run && phase_end) begin
      case (state_q)
        S_FILL: state_d = S_CW;
        S_CW:   state_d = S_P1;
        S_P1:   state_d = S_CCW;
        S_CCW:  state_d = S_P2;
        S_P2: begin
          if (agit_q != AGIT_LAST) begin
            state_d = S_CW;
            agit_d  = agit_q + 1'b1;
          end else begin
            state_d = S_DRAIN;
            agit_d  = '0;
          end
        end
        S_DRAIN: begin
          if (pass_q != PASS_LAST) begin
            state_d = S_FILL;
            pass_d  = pass_q + 1'b1;
          end else begin
            state_d = S_SPIN;
          end
        end
        S_SPIN: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
        S_ABORT: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // every state entry restarts the prescaler and phase timer
  assign adv = (state_d != state_q);

  always_comb begin
    psc_d = psc_q;
    tmr_d = tmr_q;
    if (adv) begin
      psc_d = '0;
      tmr_d = '0;
    end else if (run) begin
      psc_d = tick ? '0 : psc_q + 1'b1;
      if (tick) tmr_d = tmr_q + 1'b1;
    end
  end

  logic [1:0] motor;
  logic       win, wout;
  logic [2:0] phase;

  always_comb begin
    motor = 2'b00;
    win   = 1'b0;
    wout  = 1'b0;
    phase = 3'd0;
    case (state_q)
      S_FILL:  begin win = 1'b1; phase = 3'd1; end
      S_CW:    begin motor = 2'b01; phase = 3'd2; end
      S_CCW:   begin motor = 2'b10; phase = 3'd2; end
      S_P1, S_P2: phase = 3'd2;
      S_DRAIN: begin wout = 1'b1; phase = 3'd3; end
      S_SPIN:  begin motor = 2'b01; wout = 1'b1; phase = 3'd4; end
      S_ABORT: begin wout = 1'b1; phase = 3'd5; end
      default: phase = 3'd0;
    endcase
    // registered pause keeps actuator gating free of input-to-output paths
    if (hold_q) begin
      motor = 2'b00;
      win   = 1'b0;
      wout  = 1'b0;
    end
  end

  assign bus.motor     = motor;
  assign bus.water_in  = win;
  assign bus.water_out = wout;
  assign bus.phase     = phase;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_wash_seq_ctrl.sv
// Scoreboard bench for wash_seq_ctrl: default instance plus a short-program
// instance (TICK_DIV=1, AGIT_REP=1, RINSE_REP=0).
module tb_wash_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, pause = 1'b0, abort = 1'b0;
  int   sel = 0;

  wash_seq_if if0 ();
  wash_seq_if if1 ();

  assign if0.start = start && (sel == 0);
  assign if0.pause = pause && (sel == 0);
  assign if0.abort = abort && (sel == 0);
  assign if1.start = start && (sel == 1);
  assign if1.pause = pause && (sel == 1);
  assign if1.abort = abort && (sel == 1);

  wash_seq_ctrl u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  wash_seq_ctrl #(.TICK_DIV(1), .AGIT_REP(1), .RINSE_REP(0))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // {busy, done, phase[2:0], motor[1:0], water_in, water_out}
  logic [8:0] vec0, vec1;
  assign vec0 = {if0.busy, if0.done, if0.phase, if0.motor, if0.water_in, if0.water_out};
  assign vec1 = {if1.busy, if1.done, if1.phase, if1.motor, if1.water_in, if1.water_out};

  logic [8:0] prog[$];
  logic [8:0] exp_q[$];
  int nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [8:0] act, input logic [8:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got=%b want=%b (busy,done,phase,motor,win,wout)", tag, act, exp);
    end
  endtask

  function automatic logic [8:0] enc(bit b, bit d, int ph, int m, bit wi, bit wo);
    return {b, d, 3'(ph), 2'(m), wi, wo};
  endfunction

  task automatic seg(input int n, input logic [8:0] v);
    repeat (n) prog.push_back(v);
  endtask

  // Expected per-cycle outputs of one uninterrupted program.
  task automatic gen_prog(input int td, input int ar, input int rr);
    prog.delete();
    for (int p = 0; p <= rr; p++) begin
      seg(3 * td, enc(1, 0, 1, 0, 1, 0));
      for (int a = 0; a < ar; a++) begin
        seg(4 * td, enc(1, 0, 2, 1, 0, 0));
        seg(2 * td, enc(1, 0, 2, 0, 0, 0));
        seg(4 * td, enc(1, 0, 2, 2, 0, 0));
        seg(2 * td, enc(1, 0, 2, 0, 0, 0));
      end
      seg(3 * td, enc(1, 0, 3, 0, 0, 1));
    end
    seg(6 * td, enc(1, 0, 4, 1, 0, 1));
  endtask

  function automatic logic [8:0] at_pos(int pos, bit hold);
    int n;
    n = prog.size();
    if (pos < n) return prog[pos];
    if (pos == n) return enc(0, 1, 0, 0, 0, 0);
    if (hold && (pos - n - 1) < n) return prog[pos - n - 1];
    return 9'd0;
  endfunction

  // start sampled at edge 0; pause sampled at edges pat..pat+plen-1;
  // abort sampled from edge aat onward (held into IDLE).
  task automatic run(input int s, input int td, input int ncyc, input int pat,
                     input int plen, input int aat, input bit hold, input bit rst_end);
    logic [8:0] e, v;
    int pos;
    sel = s;
    exp_q.delete();
    for (int c = 0; c < ncyc; c++) begin
      pos = (c < pat) ? c : (c < pat + plen) ? pat - 1 : c - plen;
      e = at_pos(pos, hold);
      if (c >= pat && c < pat + plen) e[3:0] = 4'b0;
      if (aat >= 0 && c >= aat) e = (c < aat + 3 * td) ? enc(1, 0, 5, 0, 0, 1) : 9'd0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b1;
    pause = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      v = (s == 1) ? vec1 : vec0;
      e = exp_q.pop_front();
      chk($sformatf("s%0d_c%0d", s, k), v, e);
      start = hold;
      pause = (k + 1 >= pat) && (k + 1 < pat + plen);
      abort = (aat >= 0) && (k + 1 >= aat);
    end
    start = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
    if (rst_end) rst_n = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst0_dut0", vec0, 9'd0);
    chk("rst0_dut1", vec1, 9'd0);
    rst_n = 1'b1;

    gen_prog(2, 2, 1);
    run(0, 2, 140, 0, 0, -1, 1'b0, 1'b0);   // nominal, done at 132
    run(0, 2, 145, 10, 5, -1, 1'b0, 1'b0);  // pause in first CW, done at 137
    run(0, 2, 35, 0, 0, 20, 1'b0, 1'b0);    // abort during CCW
    run(0, 2, 40, 0, 0, -1, 1'b0, 1'b1);    // reset at cycle 40
    @(negedge clk);
    chk("rst_mid", vec0, 9'd0);
    rst_n = 1'b1;
    run(0, 2, 140, 0, 0, -1, 1'b0, 1'b0);   // full program after reset
    run(0, 2, 150, 0, 0, -1, 1'b1, 1'b1);   // start held: back-to-back
    @(negedge clk);
    chk("rst_b2b", vec0, 9'd0);
    rst_n = 1'b1;

    gen_prog(1, 1, 0);
    run(1, 1, 30, 0, 0, -1, 1'b0, 1'b0);    // short program, done at 24

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
